// File: rtl/pipe_ctrl_pkg.sv
// Shared constants, stall encodings and FSM state type for the pipeline controller.
package pipe_ctrl_pkg;

    localparam int unsigned STALL_W = 6;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned CNT_W   = 32;
    localparam int unsigned EP_W    = 10;

    localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;
    localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
    localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;

    localparam logic [ADDR_W-1:0] EXC_VECTOR    = 32'h0000_0020;
    localparam int unsigned       STALL_TIMEOUT = 1023;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    // Deepest requesting stage wins: it must hold everything upstream of itself.
    function automatic logic [STALL_W-1:0] stall_encode(input logic id,
                                                         input logic ex,
                                                         input logic mem);
        logic [STALL_W-1:0] enc;
        enc = STALL_NONE;
        if (mem) begin
            enc = STALL_MEM;
        end else if (ex) begin
            enc = STALL_EX;
        end else if (id) begin
            enc = STALL_ID;
        end
        return enc;
    endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/exception controller: per-stage stall, flush/redirect,
// stall-cycle statistics and a report-only stall watchdog.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                stallreq_id,
    input  logic                stallreq_ex,
    input  logic                stallreq_mem,
    input  logic                except_valid,
    input  logic                eret,
    input  logic [ADDR_W-1:0]   epc,
    input  logic                cnt_clr,
    output logic [STALL_W-1:0]  stall,
    output logic                flush,
    output logic [ADDR_W-1:0]   new_pc,
    output logic [CNT_W-1:0]    stall_cycles,
    output logic                stall_timeout
);

    state_e             state_q;
    state_e             state_d;
    logic [STALL_W-1:0] stall_c;
    logic               flush_c;
    logic [ADDR_W-1:0]  new_pc_c;
    logic               any_req_c;
    logic               stalling_c;

    logic [EP_W-1:0]    ep_q;
    logic [EP_W-1:0]    ep_d;
    logic               timeout_q;
    logic               timeout_d;

    assign any_req_c = stallreq_id | stallreq_ex | stallreq_mem;

    // Next state and zero-latency pipeline controls; reset forces all controls low.
    always_comb begin
        state_d  = state_q;
        stall_c  = STALL_NONE;
        flush_c  = 1'b0;
        new_pc_c = '0;
        unique case (state_q)
            ST_RUN, ST_STALL: begin
                if (except_valid) begin
                    flush_c  = 1'b1;
                    new_pc_c = eret ? epc : EXC_VECTOR;
                    state_d  = ST_FLUSH;
                end else begin
                    stall_c = stall_encode(stallreq_id, stallreq_ex, stallreq_mem);
                    state_d = any_req_c ? ST_STALL : ST_RUN;
                end
            end
            ST_FLUSH: begin
                // Requests this cycle come from instructions just killed.
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        if (!rst) begin
            stall_c  = STALL_NONE;
            flush_c  = 1'b0;
            new_pc_c = '0;
            state_d  = ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign stall      = stall_c;
    assign flush      = flush_c;
    assign new_pc     = new_pc_c;
    assign stalling_c = (stall_c != STALL_NONE);

    // Episode length spans priority changes; it only restarts on a stall-free cycle.
    always_comb begin
        ep_d      = '0;
        timeout_d = timeout_q;
        if (stalling_c) begin
            ep_d = (ep_q == {EP_W{1'b1}}) ? ep_q : ep_q + EP_W'(1);
            if (ep_q == EP_W'(STALL_TIMEOUT - 1)) begin
                timeout_d = 1'b1;
            end
        end
        if (cnt_clr) begin
            timeout_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ep_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            ep_q      <= ep_d;
            timeout_q <= timeout_d;
        end
    end

    assign stall_timeout = timeout_q;

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst),
        .inc_i (stalling_c),
        .clr_i (cnt_clr),
        .cnt_o (stall_cycles)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a behavioural model queues the expected
// outputs for every cycle and an independent monitor compares them.
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic        except_valid;
    logic        eret;
    logic [31:0] epc;
    logic        cnt_clr;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic [31:0] stall_cycles;
    logic        stall_timeout;

    pipe_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .stallreq_id   (stallreq_id),
        .stallreq_ex   (stallreq_ex),
        .stallreq_mem  (stallreq_mem),
        .except_valid  (except_valid),
        .eret          (eret),
        .epc           (epc),
        .cnt_clr       (cnt_clr),
        .stall         (stall),
        .flush         (flush),
        .new_pc        (new_pc),
        .stall_cycles  (stall_cycles),
        .stall_timeout (stall_timeout)
    );

    typedef struct packed {
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] new_pc;
        logic [31:0] cyc;
        logic        to;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_pushed = 0;
    bit   done     = 0;

    // Model state: stall-cycle total, current episode length, watchdog flag,
    // and whether the previous cycle redirected the pipeline.
    longint m_cyc;
    int     m_ep;
    bit     m_to;
    bit     m_post_flush;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input bit id, input bit ex, input bit mem,
                        input bit exc, input bit er, input logic [31:0] pc,
                        input bit clr, input bit rn);
        exp_t e;
        stallreq_id  = id;
        stallreq_ex  = ex;
        stallreq_mem = mem;
        except_valid = exc;
        eret         = er;
        epc          = pc;
        cnt_clr      = clr;
        rst          = rn;
        if (!rn) begin
            m_cyc = 0; m_ep = 0; m_to = 0; m_post_flush = 0;
        end
        e = '0;
        if (rn && !m_post_flush) begin
            if (exc) begin
                e.flush  = 1'b1;
                e.new_pc = er ? pc : 32'h0000_0020;
            end else if (mem) e.stall = 6'b011111;
            else if (ex)      e.stall = 6'b001111;
            else if (id)      e.stall = 6'b000111;
        end
        e.cyc = m_cyc[31:0];
        e.to  = m_to;
        exp_q.push_back(e);
        n_pushed++;
        if (rn) begin
            if (e.stall != 0) begin
                m_ep++;
                if (m_ep >= 1023) m_to = 1;
                if (m_cyc < 64'h0000_0000_FFFF_FFFF) m_cyc++;
            end else begin
                m_ep = 0;
            end
            if (clr) begin
                m_cyc = 0;
                m_to  = 0;
            end
            m_post_flush = e.flush;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 32'h0, 0, 1);
    endtask

    // Monitor: compare every presented cycle against the head of the queue.
    always @(negedge clk) begin
        if (!done && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks++;
            if (stall === e.stall && flush === e.flush && new_pc === e.new_pc &&
                stall_cycles === e.cyc && stall_timeout === e.to) begin
                n_pass++;
            end else begin
                $display("FAIL cycle_check t=%0t got stall=%b flush=%b new_pc=%h cyc=%0d to=%b exp stall=%b flush=%b new_pc=%h cyc=%0d to=%b",
                         $time, stall, flush, new_pc, stall_cycles, stall_timeout,
                         e.stall, e.flush, e.new_pc, e.cyc, e.to);
            end
        end
    end

    initial begin
        m_cyc = 0; m_ep = 0; m_to = 0; m_post_flush = 0;
        rst = 0; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
        except_valid = 0; eret = 0; epc = '0; cnt_clr = 0;
        @(posedge clk);
        #1;
        // Reset held while requests are active: outputs must stay quiet.
        step(1, 1, 1, 1, 1, 32'hdead_beef, 0, 0);
        step(0, 0, 0, 0, 0, 32'h0, 0, 0);
        idle(2);

        // Load-use stall for three cycles.
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 32'h0, 0, 1);
        idle(2);

        // Priority change without a gap.
        step(1, 0, 1, 0, 0, 32'h0, 0, 1);
        step(1, 0, 0, 0, 0, 32'h0, 0, 1);
        idle(1);

        // Exception with an EX stall pending, then stale request ignored.
        step(0, 1, 0, 1, 0, 32'h0, 0, 1);
        step(0, 1, 0, 0, 0, 32'h0, 0, 1);
        step(0, 1, 0, 0, 0, 32'h0, 0, 1);
        idle(1);

        // Return from exception.
        step(0, 0, 0, 1, 1, 32'h0040_1234, 0, 1);
        idle(2);

        // Watchdog: 1023-cycle EX stall, mixing in a priority change mid-episode.
        for (int i = 0; i < 1023; i++) step(i == 500, 1, i == 700, 0, 0, 32'h0, 0, 1);
        idle(3);
        step(0, 0, 0, 0, 0, 32'h0, 1, 1);
        idle(2);

        // 1022-cycle episode must not trip the watchdog.
        for (int i = 0; i < 1022; i++) step(0, 1, 0, 0, 0, 32'h0, 0, 1);
        idle(2);

        // Reset mid-stall, then recover.
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, 32'h0, 0, 1);
        step(0, 0, 1, 0, 0, 32'h0, 0, 0);
        step(0, 0, 1, 0, 0, 32'h0, 0, 1);
        idle(2);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 1) == 1, $urandom,
                 $urandom_range(0, 31) == 0, $urandom_range(0, 99) != 0);
        end
        idle(2);

        done = 1;
        n_checks++;
        if (n_checks - 1 == n_pushed && exp_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL scoreboard_drain got checked=%0d pending=%0d exp checked=%0d pending=0",
                     n_checks - 1, exp_q.size(), n_pushed);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  in  1  reset, asynchronous assert, active-low (0 = reset), released synchronously to clk.
REQ-003 SHALL have port: stallreq_id  in  1  ID-stage hazard stall request (load-use).
REQ-004 SHALL have port: stallreq_ex  in  1  EX-stage multi-cycle op stall request (mul/div).
REQ-005 SHALL have port: stallreq_mem  in  1  MEM-stage memory-wait stall request.
REQ-006 SHALL have port: except_valid  in  1  exception/eret committed in MEM this cycle.
REQ-007 SHALL have port: eret  in  1  qualifies except_valid as return-from-exception.
REQ-008 SHALL have port: epc  in  32  return address for eret.
REQ-009 SHALL have port: cnt_clr  in  1  synchronous clear of stall_cycles and stall_timeout.
REQ-010 SHALL have port: stall  out  6  per-stage hold; bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
REQ-011 SHALL have port: flush  out  1  kill all in-flight pipeline registers this cycle.
REQ-012 SHALL have port: new_pc  out  32  redirect target, valid when flush=1.
REQ-013 SHALL have port: stall_cycles  out  32  saturating count of cycles with stall!=0.
REQ-014 SHALL have port: stall_timeout  out  1  sticky: a single stall episode reached STALL_TIMEOUT cycles.

Function
REQ-015 SHALL drive stall, flush, new_pc combinationally from inputs and current state (zero-cycle latency; pipeline registers act in the same cycle).
REQ-016 SHALL encode stall with priority mem > ex > id: mem 6'b011111, ex 6'b001111, id 6'b000111, none 6'b000000.
REQ-017 SHALL implement FSM RUN, STALL, FLUSH; RUN->STALL when any stallreq and no except_valid; STALL->RUN when all stallreq low.
REQ-018 SHALL, when except_valid=1 in RUN or STALL, assert flush=1, force stall=0, set new_pc = eret ? epc : EXC_VECTOR, and enter FLUSH next cycle.
REQ-019 SHALL hold FLUSH exactly one cycle with flush=0, stall=0, all stallreq and except_valid ignored (stale requests from killed instructions), then go to RUN.
REQ-020 SHALL drive new_pc = 0 whenever flush=0.
REQ-021 SHALL give except_valid priority over all stall requests in the same cycle.
REQ-022 SHALL increment stall_cycles by 1 each cycle stall!=0, saturating at 32'hFFFF_FFFF; cnt_clr=1 clears it and takes priority over increment.
REQ-023 SHALL keep a 10-bit episode counter: cleared whenever stall=0, incremented while stall!=0; when it equals STALL_TIMEOUT-1 with stall!=0, set stall_timeout next edge.
REQ-024 SHALL keep stall_timeout set until cnt_clr or reset; stalling continues unaffected (watchdog is report-only).
REQ-025 SHALL keep the episode counter running across a change of stall priority without a stall=0 gap.

Reset
REQ-026 SHALL, on rst=0, asynchronously set state=RUN, stall_cycles=0, episode counter=0, stall_timeout=0.
REQ-027 SHALL, while rst=0, drive stall=0, flush=0, new_pc=0 regardless of inputs.
REQ-028 SHALL, if reset asserts during STALL or FLUSH, abandon the episode; first cycle after release behaves as RUN.

Structure
REQ-029 SHALL take stall encodings, EXC_VECTOR (32'h0000_0020), STALL_TIMEOUT (1023) and FSM state encodings from defines.vh.
REQ-030 SHALL instantiate one sub-module sat_counter (parameterised width, inc, clr, saturate) for stall_cycles.
REQ-031 SHALL fit in 120-400 lines of RTL.

Verification
REQ-032 SHALL test: stallreq_id=1 for 3 cycles -> stall=6'b000111 for 3 cycles, stall_cycles=3, then stall=0.
REQ-033 SHALL test: stallreq_id=1 and stallreq_mem=1 together -> stall=6'b011111; drop mem -> 6'b000111 same cycle.
REQ-034 SHALL test: except_valid=1, eret=0 with stallreq_ex=1 -> flush=1, stall=0, new_pc=32'h0000_0020; next cycle flush=0, stall=0 despite stallreq_ex=1.
REQ-035 SHALL test: except_valid=1, eret=1, epc=32'h0040_1234 -> new_pc=32'h0040_1234, flush=1 for exactly one cycle.
REQ-036 SHALL test: stallreq_ex held 1023 cycles -> stall_timeout=1 after the 1023rd stalled cycle, remains 1 after release, cleared by cnt_clr=1.
REQ-037 SHALL test: rst=0 asserted mid-STALL -> stall=0 immediately, stall_cycles=0, state RUN after release.
